// File: rtl/goodness_unit.sv
// Forward-Forward goodness evaluator: streams one layer's Q16.16 activations out of the
// buffer, sums their squares, and reports a saturated goodness plus a threshold decision.
module goodness_unit #(
    parameter int NUM_NEURONS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH-FRAC_BITS+$clog2(NUM_NEURONS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DATA_WIDTH-1:0]          threshold,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_NEURONS)-1:0] act_addr,
    output logic                           act_en,
    input  logic [DATA_WIDTH-1:0]          act_rdata,
    output logic [DATA_WIDTH-1:0]          goodness,
    output logic                           is_positive
);
    localparam int AW   = $clog2(NUM_NEURONS);
    localparam int SQ_W = 2*DATA_WIDTH-FRAC_BITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  en_q, en_d;
    logic                  en_d1_q, en_d1_d;
    logic [SQ_W-1:0]       sq_q, sq_d;
    logic                  sq_vld_q, sq_vld_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0] thr_q, thr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] goodness_q, goodness_d;
    logic                  pos_q, pos_d;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [SQ_W-1:0]                sq_full;
    logic signed [ACC_WIDTH:0]      acc_s;
    logic signed [ACC_WIDTH:0]      thr_s;
    logic                           sat;

    always_comb begin
        // The square is never negative, so a logical shift equals floor truncation.
        prod    = $signed(act_rdata) * $signed(act_rdata);
        sq_full = SQ_W'(prod >> FRAC_BITS);

        acc_s = $signed({1'b0, acc_q});
        thr_s = $signed({{(ACC_WIDTH+1-DATA_WIDTH){thr_q[DATA_WIDTH-1]}}, thr_q});
        sat   = |acc_q[ACC_WIDTH-1:DATA_WIDTH-1];
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        en_d       = en_q;
        thr_d      = thr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        goodness_d = goodness_q;
        pos_d      = pos_q;

        en_d1_d  = en_q;
        sq_vld_d = en_d1_q;
        sq_d     = en_d1_q ? sq_full : sq_q;
        acc_d    = sq_vld_q ? acc_q + {{(ACC_WIDTH-SQ_W){1'b0}}, sq_q} : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    thr_d   = threshold;
                    acc_d   = '0;
                end
            end
            S_READ: begin
                if (addr_q == AW'(NUM_NEURONS-1)) begin
                    en_d    = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // Once the delayed enable drops, the last square is in stage 2.
                if (!en_d1_q) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                goodness_d = sat ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : acc_q[DATA_WIDTH-1:0];
                pos_d      = acc_s > thr_s;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            en_q       <= 1'b0;
            en_d1_q    <= 1'b0;
            sq_q       <= '0;
            sq_vld_q   <= 1'b0;
            acc_q      <= '0;
            thr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            goodness_q <= '0;
            pos_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            en_d1_q    <= en_d1_d;
            sq_q       <= sq_d;
            sq_vld_q   <= sq_vld_d;
            acc_q      <= acc_d;
            thr_q      <= thr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            goodness_q <= goodness_d;
            pos_q      <= pos_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign act_addr    = addr_q;
    assign act_en      = en_q;
    assign goodness    = goodness_q;
    assign is_positive = pos_q;
endmodule
